mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and load/store (D) traffic.
//  D is driven by the decoder's memRW code (00 none, 01 read, 10 write, 11 illegal).

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter_watchdog.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Purpose: data-side access codes, arbiter FSM states, owner codes, watchdog width.
// Ports: none (package).
package mem_port_arbiter_pkg;

    // Decoder memRW codes on the data port.
    typedef enum logic [1:0] {
        MEMRW_NONE    = 2'b00,
        MEMRW_READ    = 2'b01,
        MEMRW_WRITE   = 2'b10,
        MEMRW_ILLEGAL = 2'b11
    } memrw_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    // Wide enough for the largest supported timeout (65535).
    localparam int WD_CNT_W = 16;

    // True for the two memRW codes that actually touch memory.
    function automatic logic is_access(input logic [1:0] memrw);
        return (memrw == MEMRW_READ) || (memrw == MEMRW_WRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single-port memory bus between arbiter and memory
// Purpose: bundles the memory request/response handshake.
// Ports (signals):
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask : arbiter -> memory request
//   mem_ready                                   : memory accepts request this cycle
//   mem_rvalid/mem_rdata                        : memory read response
// Modports: master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// rtl/mem_port_arbiter_watchdog.sv - transaction watchdog counter for the arbiter
// Purpose: counts cycles spent waiting on memory and flags expiry.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the count (transaction granted)
//   enable    : count this cycle (waiting in REQ/RESP)
//   expired   : this is the TIMEOUT_CYC-th waiting cycle
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [WD_CNT_W-1:0] LAST = WD_CNT_W'(TIMEOUT_CYC - 1);

    logic [WD_CNT_W-1:0] count_q, count_d;

    // Holds at LAST so a missed completion can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // count_q is the number of waiting cycles already elapsed, so the
    // TIMEOUT_CYC-th waiting cycle sees LAST.
    assign expired = enable && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store
// Purpose: one outstanding transaction, data side has priority, stall freezes the
//          pipeline while a transaction is pending, watchdog forces completion.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   if_req/if_addr               : fetch request (held until if_rvalid)
//   if_rvalid/if_rdata           : fetch completion pulse and registered word
//   d_memRW/d_addr/d_wdata/d_wmask : data request (held until d_done)
//   d_done/d_rdata               : data completion pulse and registered load word
//   stall                        : hold PC and pipeline registers
//   mem                          : memory bus (master side)
//   err_illegal/err_timeout      : error pulses
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic [1:0]        d_memRW,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    mem_port_arbiter_if.master mem,
    output logic              err_illegal,
    output logic              err_timeout
);
    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic              mem_req_q, mem_req_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_timeout_q, err_timeout_d;

    logic              grant;
    logic              complete;
    logic              rdata_wr;
    logic [DATA_W-1:0] rdata_val;
    logic              wd_expired;

    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .enable  ((state_q == ST_REQ) || (state_q == ST_RESP)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_rvalid_d   = 1'b0;
        d_done_d      = 1'b0;
        err_illegal_d = 1'b0;
        err_timeout_d = 1'b0;
        grant         = 1'b0;
        complete      = 1'b0;
        rdata_wr      = 1'b0;
        rdata_val     = '0;

        case (state_q)
            ST_IDLE: begin
                if (is_access(d_memRW)) begin
                    owner_d = OWNER_D;
                    addr_d  = d_addr;
                    we_d    = (d_memRW == MEMRW_WRITE);
                    wdata_d = d_wdata;
                    wmask_d = d_wmask;
                    state_d = ST_REQ;
                    grant   = 1'b1;
                end else if (d_memRW == MEMRW_ILLEGAL) begin
                    // Retired without touching memory.
                    owner_d       = OWNER_D;
                    state_d       = ST_DONE;
                    complete      = 1'b1;
                    err_illegal_d = 1'b1;
                end else if (if_req) begin
                    owner_d = OWNER_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = ST_REQ;
                    grant   = 1'b1;
                end
            end
            ST_REQ: begin
                // A real acceptance wins over a same-cycle watchdog expiry.
                if (mem.mem_ready) begin
                    if (we_q) begin
                        state_d  = ST_DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (wd_expired) begin
                    state_d       = ST_DONE;
                    complete      = 1'b1;
                    rdata_wr      = 1'b1;
                    err_timeout_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (mem.mem_rvalid) begin
                    state_d   = ST_DONE;
                    complete  = 1'b1;
                    rdata_wr  = 1'b1;
                    rdata_val = mem.mem_rdata;
                end else if (wd_expired) begin
                    state_d       = ST_DONE;
                    complete      = 1'b1;
                    rdata_wr      = 1'b1;
                    err_timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                // No grant here: requesters get one edge to drop their request.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            if (owner_d == OWNER_IF) begin
                if_rvalid_d = 1'b1;
            end else begin
                d_done_d = 1'b1;
            end
        end

        if (rdata_wr) begin
            if (owner_d == OWNER_IF) begin
                if_rdata_d = rdata_val;
            end else begin
                d_rdata_d = rdata_val;
            end
        end

        mem_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWNER_IF;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            mem_req_q     <= 1'b0;
            if_rvalid_q   <= 1'b0;
            if_rdata_q    <= '0;
            d_done_q      <= 1'b0;
            d_rdata_q     <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            mem_req_q     <= mem_req_d;
            if_rvalid_q   <= if_rvalid_d;
            if_rdata_q    <= if_rdata_d;
            d_done_q      <= d_done_d;
            d_rdata_q     <= d_rdata_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // stall must rise in the same cycle a request appears, so the IDLE term
    // looks at the live request inputs.
    assign stall = ((state_q == ST_IDLE) && (if_req || (d_memRW != MEMRW_NONE)))
                 || (state_q == ST_REQ) || (state_q == ST_RESP);

    assign if_rvalid     = if_rvalid_q;
    assign if_rdata      = if_rdata_q;
    assign d_done        = d_done_q;
    assign d_rdata       = d_rdata_q;
    assign err_illegal   = err_illegal_q;
    assign err_timeout   = err_timeout_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wmask = wmask_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    localparam int K_FETCH   = 0;
    localparam int K_LOAD    = 1;
    localparam int K_STORE   = 2;
    localparam int K_ILLEGAL = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic [1:0]        d_memRW;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wmask;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              stall;
    logic              err_illegal;
    logic              err_timeout;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_memRW     (d_memRW),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wmask     (d_wmask),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .stall       (stall),
        .mem         (mem_bus),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents as seen by the bench: unwritten words follow a fixed pattern.
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m);
        logic [31:0] cur;
        cur = model_read(a);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) cur[8*b +: 8] = w[8*b +: 8];
        end
        mem_model[a] = cur;
    endfunction

    // Runs one transaction whose request is already on the inputs in the current
    // cycle (k=0). r = cycles before mem_ready, v = cycles from accept to rvalid,
    // dead: 0 healthy, 1 mem_ready never comes, 2 mem_rvalid never comes.
    // Expected timeline: REQ occupies cycles 1..r+1, RESP r+2..r+v+1, then DONE.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input int r, input int v, input int dead);
        int          done_c, req_last, resp_first, resp_last;
        logic [31:0] rd_val;
        logic        in_req, in_resp, at_done;
        logic [31:0] exp_rdata;

        if (kind == K_ILLEGAL) done_c = 1;
        else if (dead != 0)    done_c = TIMEOUT + 1;
        else if (kind == K_STORE) done_c = r + 2;
        else                   done_c = r + v + 2;

        if (kind == K_ILLEGAL) req_last = 0;
        else if (dead == 1)    req_last = TIMEOUT;
        else                   req_last = r + 1;

        resp_first = req_last + 1;
        resp_last  = ((kind == K_FETCH || kind == K_LOAD) && dead != 1) ? done_c - 1 : resp_first - 1;
        rd_val     = model_read(addr);
        exp_rdata  = (dead != 0) ? 32'h0 : rd_val;

        for (int k = 0; k <= done_c; k++) begin
            in_req  = (k >= 1) && (k <= req_last);
            in_resp = (k >= resp_first) && (k <= resp_last);
            at_done = (k == done_c);

            mem_bus.mem_ready  = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata  = $urandom;
            if (in_req) begin
                if (dead != 1 && k == req_last) mem_bus.mem_ready = 1'b1;
                if ($urandom_range(0, 3) == 0) mem_bus.mem_rvalid = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) mem_bus.mem_ready = 1'b1;
            end
            if (in_resp) begin
                mem_bus.mem_rvalid = (dead == 0) && (k == resp_last);
                if (mem_bus.mem_rvalid) mem_bus.mem_rdata = rd_val;
            end else if (!in_req && $urandom_range(0, 3) == 0) begin
                mem_bus.mem_rvalid = 1'b1;
            end
            // A held data request may wander once captured; it must not matter.
            if (k >= 1 && kind != K_FETCH && d_memRW != 2'b00) begin
                d_memRW = 2'($urandom_range(1, 3));
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wmask = 4'($urandom);
            end

            @(negedge clk);
            expect_eq("mem_req", mem_bus.mem_req, in_req);
            if (in_req) begin
                expect_eq("mem_addr", mem_bus.mem_addr, addr);
                expect_eq("mem_we", mem_bus.mem_we, kind == K_STORE);
                if (kind == K_STORE) begin
                    expect_eq("mem_wdata", mem_bus.mem_wdata, wdata);
                    expect_eq("mem_wmask", mem_bus.mem_wmask, wmask);
                end
            end
            expect_eq("stall", stall, k < done_c);
            expect_eq("if_rvalid", if_rvalid, at_done && kind == K_FETCH);
            expect_eq("d_done", d_done, at_done && kind != K_FETCH);
            expect_eq("err_illegal", err_illegal, at_done && kind == K_ILLEGAL);
            expect_eq("err_timeout", err_timeout, at_done && dead != 0);
            if (at_done) begin
                if (kind == K_FETCH) expect_eq("if_rdata", if_rdata, exp_rdata);
                if (kind == K_LOAD) expect_eq("d_rdata", d_rdata, exp_rdata);
                if (kind == K_STORE && dead != 0) expect_eq("d_rdata_timeout", d_rdata, 32'h0);
                if (kind == K_STORE && dead == 0) model_write(addr, wdata, wmask);
                if (kind == K_FETCH) if_req = 1'b0;
                else d_memRW = 2'b00;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if_req             = 1'b0;
            d_memRW            = 2'b00;
            mem_bus.mem_ready  = 1'($urandom_range(0, 1));
            mem_bus.mem_rvalid = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata  = $urandom;
            @(negedge clk);
            expect_eq("idle_stall", stall, 1'b0);
            expect_eq("idle_mem_req", mem_bus.mem_req, 1'b0);
            expect_eq("idle_if_rvalid", if_rvalid, 1'b0);
            expect_eq("idle_d_done", d_done, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_d(input int kind, input logic [31:0] a, input logic [31:0] w, input logic [3:0] m);
        d_memRW = (kind == K_LOAD) ? 2'b01 : (kind == K_STORE) ? 2'b10 : 2'b11;
        d_addr  = a;
        d_wdata = w;
        d_wmask = m;
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq({tag, "_outs"},
                  {if_rvalid, d_done, stall, err_illegal, err_timeout, mem_bus.mem_req, mem_bus.mem_we},
                  7'b0);
        expect_eq({tag, "_if_rdata"}, if_rdata, 32'h0);
        expect_eq({tag, "_d_rdata"}, d_rdata, 32'h0);
        expect_eq({tag, "_mem_addr"}, mem_bus.mem_addr, 32'h0);
    endtask

    initial begin
        int          kind, r, v, dead;
        logic [31:0] a;
        logic        collide;

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_memRW = 2'b00; d_addr = '0; d_wdata = '0; d_wmask = '0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // Fetch read with immediate memory.
        mem_model[32'h100] = 32'h00A0_0093;
        if_req = 1'b1; if_addr = 32'h100;
        run_txn(K_FETCH, 32'h100, 32'h0, 4'h0, 0, 1, 0);
        idle_cycles(1);

        // Collision: data wins, fetch follows right after DONE.
        if_req = 1'b1; if_addr = 32'h180;
        apply_d(K_LOAD, 32'h200, 32'h0, 4'h0);
        run_txn(K_LOAD, 32'h200, 32'h0, 4'h0, 0, 1, 0);
        run_txn(K_FETCH, 32'h180, 32'h0, 4'h0, 1, 2, 0);
        idle_cycles(1);

        // Store with delayed acceptance, then read it back.
        apply_d(K_STORE, 32'h40, 32'hCAFE_F00D, 4'hF);
        run_txn(K_STORE, 32'h40, 32'hCAFE_F00D, 4'hF, 4, 1, 0);
        apply_d(K_LOAD, 32'h40, 32'h0, 4'h0);
        run_txn(K_LOAD, 32'h40, 32'h0, 4'h0, 0, 1, 0);
        expect_eq("store_readback", d_rdata, 32'hCAFE_F00D);

        // Illegal code retires without memory access.
        apply_d(K_ILLEGAL, 32'h44, 32'h0, 4'h0);
        run_txn(K_ILLEGAL, 32'h44, 32'h0, 4'h0, 0, 1, 0);

        // Dead memory: watchdog fires after TIMEOUT REQ cycles.
        if_req = 1'b1; if_addr = 32'h104;
        run_txn(K_FETCH, 32'h104, 32'h0, 4'h0, 0, 1, 1);
        idle_cycles(1);

        for (int n = 0; n < 70; n++) begin
            kind    = (($urandom_range(0, 9) == 0) ? K_ILLEGAL : int'($urandom_range(0, 2)));
            a       = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            r       = $urandom_range(0, 3);
            v       = $urandom_range(1, 3);
            dead    = 0;
            if (kind != K_ILLEGAL && $urandom_range(0, 7) == 0)
                dead = (kind == K_STORE) ? 1 : int'($urandom_range(1, 2));
            collide = (kind != K_FETCH) && ($urandom_range(0, 2) == 0);
            if (kind == K_FETCH) begin
                if_req = 1'b1; if_addr = a;
                run_txn(K_FETCH, a, 32'h0, 4'h0, r, v, dead);
            end else begin
                apply_d(kind, a, $urandom, 4'($urandom));
                if (collide) begin
                    if_req = 1'b1; if_addr = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
                end
                run_txn(kind, a, d_wdata, d_wmask, r, v, dead);
                if (collide) run_txn(K_FETCH, if_addr, 32'h0, 4'h0,
                                     int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 0);
            end
            idle_cycles($urandom_range(0, 2));
        end

        // Make sure both rdata registers hold something before the mid-transaction reset.
        apply_d(K_LOAD, 32'h40, 32'h0, 4'h0);
        run_txn(K_LOAD, 32'h40, 32'h0, 4'h0, 0, 1, 0);
        if_req = 1'b1; if_addr = 32'h100;
        run_txn(K_FETCH, 32'h100, 32'h0, 4'h0, 0, 1, 0);

        // Reset while in RESP abandons the read.
        if_req = 1'b1; if_addr = 32'h300;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        mem_bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        expect_eq("resp_stall", stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        if_req = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check_all_zero("rst_resp");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_bus.mem_ready  = 1'($urandom_range(0, 1));
            mem_bus.mem_rvalid = 1'b1;
            @(negedge clk);
            expect_eq("stray_if_rvalid", if_rvalid, 1'b0);
            expect_eq("stray_d_done", d_done, 1'b0);
            expect_eq("stray_mem_req", mem_bus.mem_req, 1'b0);
            expect_eq("stray_if_rdata", if_rdata, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
